// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions for the encode (display driver) and capture sides.
// Patterns are active-low, bit order g..a ([6]=g, [0]=a).
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned SEG_BUS_W  = 8;
    localparam int unsigned NIB_W      = 4;

    typedef logic [SEG_W-1:0] seg_pat_t;

    localparam seg_pat_t SEG_HEX_0 = 7'b1000000;
    localparam seg_pat_t SEG_HEX_1 = 7'b1111001;
    localparam seg_pat_t SEG_HEX_2 = 7'b0100100;
    localparam seg_pat_t SEG_HEX_3 = 7'b0110000;
    localparam seg_pat_t SEG_HEX_4 = 7'b0011001;
    localparam seg_pat_t SEG_HEX_5 = 7'b0010010;
    localparam seg_pat_t SEG_HEX_6 = 7'b0000010;
    localparam seg_pat_t SEG_HEX_7 = 7'b1111000;
    localparam seg_pat_t SEG_HEX_8 = 7'b0000000;
    localparam seg_pat_t SEG_HEX_9 = 7'b0010000;
    localparam seg_pat_t SEG_HEX_A = 7'b0001000;
    localparam seg_pat_t SEG_HEX_B = 7'b0000011;
    localparam seg_pat_t SEG_HEX_C = 7'b1000110;
    localparam seg_pat_t SEG_HEX_D = 7'b0100001;
    localparam seg_pat_t SEG_HEX_E = 7'b0000110;
    localparam seg_pat_t SEG_HEX_F = 7'b0001110;

    // Decoded digit: hex nibble plus "pattern not in table" flag
    typedef struct packed {
        logic [NIB_W-1:0] nibble;
        logic             bad;
    } seg_dec_t;

    // Nibble -> pattern, for the encode direction
    function automatic seg_pat_t seg_encode(input logic [NIB_W-1:0] nib);
        seg_pat_t pat;
        case (nib)
            4'h0:    pat = SEG_HEX_0;
            4'h1:    pat = SEG_HEX_1;
            4'h2:    pat = SEG_HEX_2;
            4'h3:    pat = SEG_HEX_3;
            4'h4:    pat = SEG_HEX_4;
            4'h5:    pat = SEG_HEX_5;
            4'h6:    pat = SEG_HEX_6;
            4'h7:    pat = SEG_HEX_7;
            4'h8:    pat = SEG_HEX_8;
            4'h9:    pat = SEG_HEX_9;
            4'hA:    pat = SEG_HEX_A;
            4'hB:    pat = SEG_HEX_B;
            4'hC:    pat = SEG_HEX_C;
            4'hD:    pat = SEG_HEX_D;
            4'hE:    pat = SEG_HEX_E;
            default: pat = SEG_HEX_F;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern -> {nibble, bad} decoder (active-low input).
module seg7_decode
    import seg7_pkg::*;
(
    input  seg_pat_t i_pat,
    output seg_dec_t o_dec_c
);

    // Table lookup; anything outside the 16 glyphs decodes to 0 and is flagged
    always_comb begin
        o_dec_c.nibble = 4'h0;
        o_dec_c.bad    = 1'b0;
        case (i_pat)
            SEG_HEX_0: o_dec_c.nibble = 4'h0;
            SEG_HEX_1: o_dec_c.nibble = 4'h1;
            SEG_HEX_2: o_dec_c.nibble = 4'h2;
            SEG_HEX_3: o_dec_c.nibble = 4'h3;
            SEG_HEX_4: o_dec_c.nibble = 4'h4;
            SEG_HEX_5: o_dec_c.nibble = 4'h5;
            SEG_HEX_6: o_dec_c.nibble = 4'h6;
            SEG_HEX_7: o_dec_c.nibble = 4'h7;
            SEG_HEX_8: o_dec_c.nibble = 4'h8;
            SEG_HEX_9: o_dec_c.nibble = 4'h9;
            SEG_HEX_A: o_dec_c.nibble = 4'hA;
            SEG_HEX_B: o_dec_c.nibble = 4'hB;
            SEG_HEX_C: o_dec_c.nibble = 4'hC;
            SEG_HEX_D: o_dec_c.nibble = 4'hD;
            SEG_HEX_E: o_dec_c.nibble = 4'hE;
            SEG_HEX_F: o_dec_c.nibble = 4'hF;
            default:   o_dec_c.bad    = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// Multiplexed 4-digit 7-segment sniffer: synchronizes SEG_N/DIG, debounces each
// digit, decodes it and publishes a 16-bit frame once all four digits are seen.
// Optional macro SEG7_CAPTURE_BCD_EN: A-F count as errors and a binary BIN output
// (d3*1000 + d2*100 + d1*10 + d0) is added.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  SEG_N,
    input  logic [3:0]  DIG,
    output logic [15:0] VALUE,
    output logic [3:0]  DOTS,
    output logic        VALID,
    output logic        ERR,
    output logic        BLANK_SEEN
`ifdef SEG7_CAPTURE_BCD_EN
    ,
    output logic [13:0] BIN
`endif
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned DIG_W = NUM_DIGITS;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [SYNC_STAGES-1:0][SEG_BUS_W-1:0] r_seg_sync;
    logic [SYNC_STAGES-1:0][DIG_W-1:0]     r_dig_sync;
    logic [SEG_BUS_W-1:0]                  r_prev_seg;
    logic [DIG_W-1:0]                      r_prev_dig;
    logic [CNT_W-1:0]                      r_cnt;
    logic [DIG_W-1:0]                      r_mask;
    logic [DIG_W-1:0][NIB_W-1:0]           r_slot_nib;
    logic [DIG_W-1:0]                      r_slot_dot;
    logic [DIG_W-1:0]                      r_slot_bad;
    logic [15:0]                           r_value;
    logic [DIG_W-1:0]                      r_dots;
    logic                                  r_valid;
    logic                                  r_err;
    logic                                  r_blank_seen;

    logic [SEG_BUS_W-1:0] w_seg;
    logic [DIG_W-1:0]     w_dig;
    logic                 w_multi;
    logic                 w_one_hot;
    logic                 w_same;
    logic [CNT_W-1:0]     w_cnt_next;
    logic                 w_capture;
    logic                 w_frame_done;
    logic                 w_bad;
    seg_dec_t             w_dec;

    assign w_seg        = r_seg_sync[SYNC_STAGES-1];
    assign w_dig        = r_dig_sync[SYNC_STAGES-1];
    assign w_multi      = (w_dig & (w_dig - DIG_W'(1))) != '0;
    assign w_one_hot    = (w_dig != '0) && !w_multi;
    assign w_same       = {w_dig, w_seg} == {r_prev_dig, r_prev_seg};
    assign w_frame_done = (r_mask == '1);

    seg7_decode u_decode (
        .i_pat   (w_seg[SEG_W-1:0]),
        .o_dec_c (w_dec)
    );

`ifdef SEG7_CAPTURE_BCD_EN
    assign w_bad = w_dec.bad || (w_dec.nibble > 4'h9);
`else
    assign w_bad = w_dec.bad;
`endif

    // Input synchronizers and previous-sample register for the stability compare
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_seg_sync <= '0;
            r_dig_sync <= '0;
            r_prev_seg <= '0;
            r_prev_dig <= '0;
        end else begin
            r_seg_sync <= {r_seg_sync[SYNC_STAGES-2:0], SEG_N};
            r_dig_sync <= {r_dig_sync[SYNC_STAGES-2:0], DIG};
            r_prev_seg <= w_seg;
            r_prev_dig <= w_dig;
        end
    end

    // Stability counter: blank clears, change reloads to 1, repeat counts up and saturates
    always_comb begin
        w_cnt_next = r_cnt;
        if (!w_one_hot) begin
            w_cnt_next = '0;
        end else if (!w_same) begin
            w_cnt_next = CNT_W'(1);
        end else if (r_cnt != CNT_MAX) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    // Capture exactly once, on the cycle the count first reaches the threshold
    assign w_capture = (w_cnt_next == CNT_MAX) && (r_cnt != CNT_MAX);

    // Stability counter register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    // Shadow slots and capture mask; a capture on the completion cycle survives the clear
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_mask     <= '0;
            r_slot_nib <= '0;
            r_slot_dot <= '0;
            r_slot_bad <= '0;
        end else begin
            for (int i = 0; i < int'(DIG_W); i++) begin
                if (w_capture && w_dig[i]) begin
                    r_mask[i]     <= 1'b1;
                    r_slot_nib[i] <= w_dec.nibble;
                    r_slot_dot[i] <= ~w_seg[SEG_BUS_W-1];
                    r_slot_bad[i] <= w_bad;
                end else if (w_frame_done) begin
                    r_mask[i]     <= 1'b0;
                    r_slot_bad[i] <= 1'b0;
                end
            end
        end
    end

    // Publish the assembled frame the cycle after the mask fills
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_value <= '0;
            r_dots  <= '0;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_frame_done;
            if (w_frame_done) begin
                r_value <= r_slot_nib;
                r_dots  <= r_slot_dot;
                r_err   <= |r_slot_bad;
            end
        end
    end

    // Sticky flag for overlapping digit strobes
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_blank_seen <= 1'b0;
        end else if (w_multi) begin
            r_blank_seen <= 1'b1;
        end
    end

`ifdef SEG7_CAPTURE_BCD_EN
    localparam int unsigned BIN_W = 14;

    logic [BIN_W-1:0] w_bin;
    logic [BIN_W-1:0] r_bin;

    assign w_bin = BIN_W'(r_slot_nib[3]) * BIN_W'(1000)
                 + BIN_W'(r_slot_nib[2]) * BIN_W'(100)
                 + BIN_W'(r_slot_nib[1]) * BIN_W'(10)
                 + BIN_W'(r_slot_nib[0]);

    // Binary value registered alongside VALUE
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_bin <= '0;
        end else if (w_frame_done) begin
            r_bin <= w_bin;
        end
    end

    assign BIN = r_bin;
`endif

    assign VALUE      = r_value;
    assign DOTS       = r_dots;
    assign VALID      = r_valid;
    assign ERR        = r_err;
    assign BLANK_SEEN = r_blank_seen;

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: directed scans plus random scanning, checked against a
// run-length / frame-assembly reference model through an expected-frame queue.
module tb_seg7_capture;

    localparam int STABLE = 64;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  SEG_N = 8'hFF;
    logic [3:0]  DIG = 4'h0;
    logic [15:0] VALUE;
    logic [3:0]  DOTS;
    logic        VALID;
    logic        ERR;
    logic        BLANK_SEEN;
`ifdef SEG7_CAPTURE_BCD_EN
    logic [13:0] BIN;
`endif

    seg7_capture #(.SYNC_STAGES(2), .STABLE_CYCLES(STABLE)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .SEG_N      (SEG_N),
        .DIG        (DIG),
        .VALUE      (VALUE),
        .DOTS       (DOTS),
        .VALID      (VALID),
        .ERR        (ERR),
        .BLANK_SEEN (BLANK_SEEN)
`ifdef SEG7_CAPTURE_BCD_EN
        ,
        .BIN        (BIN)
`endif
    );

    always #5 CLK = ~CLK;

    // Active-low g..a glyphs 0..F
    logic [6:0] tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dots;
        logic        err;
        logic [13:0] bin;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state
    logic [11:0] run_val;
    int          run_len;
    logic [3:0]  m_mask;
    int          m_nib [4];
    logic [3:0]  m_dot;
    logic [3:0]  m_bad;
    bit          m_pend;
    bit          m_blank;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pat(input int nib, input bit dot);
        logic [6:0] p;
        p = tab[nib];
        return {~dot, p};
    endfunction

    task automatic model_reset();
        run_val = '0; run_len = 0; m_mask = '0; m_dot = '0; m_bad = '0;
        m_pend = 0; m_blank = 0;
        for (int i = 0; i < 4; i++) m_nib[i] = 0;
    endtask

    // One sampled cycle of raw input, as seen by the design after synchronization
    task automatic model_step(input logic [3:0] d, input logic [7:0] s);
        exp_t e;
        int   nib;
        bit   bad;
        if (m_pend) begin
            e.value = {4'(m_nib[3]), 4'(m_nib[2]), 4'(m_nib[1]), 4'(m_nib[0])};
            e.dots  = m_dot;
            e.err   = |m_bad;
            e.bin   = 14'((m_nib[3] * 1000 + m_nib[2] * 100 + m_nib[1] * 10 + m_nib[0]) % 16384);
            exp_q.push_back(e);
            m_mask = '0; m_bad = '0; m_pend = 0;
        end
        if ($countones(d) == 1) begin
            if (run_len > 0 && {d, s} == run_val) run_len++;
            else begin run_val = {d, s}; run_len = 1; end
            if (run_len == STABLE) begin
                nib = 0; bad = 1;
                for (int k = 0; k < 16; k++) if (tab[k] == s[6:0]) begin nib = k; bad = 0; end
`ifdef SEG7_CAPTURE_BCD_EN
                if (nib > 9) bad = 1;
`endif
                for (int i = 0; i < 4; i++) if (d[i]) begin
                    m_nib[i] = nib; m_dot[i] = ~s[7]; m_bad[i] = bad; m_mask[i] = 1'b1;
                end
            end
        end else begin
            run_len = 0;
            if ($countones(d) > 1) m_blank = 1;
        end
        if (m_mask == 4'hF) m_pend = 1;
    endtask

    task automatic hold(input logic [3:0] d, input logic [7:0] s, input int n);
        for (int k = 0; k < n; k++) begin
            DIG = d; SEG_N = s;
            @(posedge CLK);
            model_step(d, s);
            #1;
        end
    endtask

    // Scan digits 0..3 with nibble values n0..n3, dots bitmask, len cycles each
    task automatic frame(input int n0, input int n1, input int n2, input int n3,
                         input logic [3:0] dots, input int len);
        hold(4'b0001, pat(n0, dots[0]), len);
        hold(4'b0010, pat(n1, dots[1]), len);
        hold(4'b0100, pat(n2, dots[2]), len);
        hold(4'b1000, pat(n3, dots[3]), len);
    endtask

    task automatic chk_out(input string tag, input logic [15:0] v, input logic [3:0] d, input logic e);
        @(negedge CLK);
        chk({tag, "_value"}, 32'(VALUE), 32'(v));
        chk({tag, "_dots"},  32'(DOTS),  32'(d));
        chk({tag, "_err"},   32'(ERR),   32'(e));
    endtask

    // Scoreboard monitor: every VALID pulse must match the next expected frame
    always @(negedge CLK) begin
        if (!RST && VALID) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'(VALUE), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_value", 32'(VALUE), 32'(e.value));
                chk("sb_dots",  32'(DOTS),  32'(e.dots));
                chk("sb_err",   32'(ERR),   32'(e.err));
`ifdef SEG7_CAPTURE_BCD_EN
                chk("sb_bin",   32'(BIN),   32'(e.bin));
`endif
            end
        end
    end

    initial begin
        logic [3:0] multi [5] = '{4'b0000, 4'b0011, 4'b0101, 4'b1100, 4'b1111};
        logic [3:0] rd;
        logic [7:0] rs;
        int         rl;

        model_reset();
        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_value", 32'(VALUE), 32'h0);
        chk("rst_dots",  32'(DOTS),  32'h0);
        chk("rst_valid", 32'(VALID), 32'h0);
        chk("rst_err",   32'(ERR),   32'h0);
        chk("rst_blank", 32'(BLANK_SEEN), 32'h0);
        @(posedge CLK); #1;
        RST = 1'b0;

        // Nominal scan 4,3,2,1 with dot on digit 2
        frame(4, 3, 2, 1, 4'b0100, 100);
        chk_out("nominal", 16'h1234, 4'b0100, 1'b0);
        chk("nominal_blank", 32'(BLANK_SEEN), 32'h0);

        // Glitching digit 1: overwrite then toggle faster than the threshold
        hold(4'b0001, pat(4, 0), 100);
        hold(4'b0010, pat(7, 0), 100);
        for (int t = 0; t < 6; t++) hold(4'b0010, pat((t % 2) ? 3 : 9, 0), 10);
        hold(4'b0010, pat(3, 0), 100);
        hold(4'b0100, pat(2, 0), 100);
        hold(4'b1000, pat(1, 0), 100);
        chk_out("glitch", 16'h1234, 4'b0000, 1'b0);

        // Undecodable digit 3, then a clean frame
        hold(4'b0001, pat(4, 0), 100);
        hold(4'b0010, pat(3, 0), 100);
        hold(4'b0100, pat(2, 0), 100);
        hold(4'b1000, 8'hFF, 100);
        chk_out("bad", 16'h0234, 4'b0000, 1'b1);
        frame(4, 3, 2, 1, 4'b0000, 100);
        chk_out("clean", 16'h1234, 4'b0000, 1'b0);

        // Blank gaps and one overlapping strobe cycle
        hold(4'b0001, pat(4, 1), 100);
        hold(4'b0000, 8'hFF, 5);
        hold(4'b0011, pat(3, 0), 1);
        hold(4'b0000, 8'hFF, 3);
        hold(4'b0010, pat(3, 0), 100);
        hold(4'b0000, 8'hFF, 4);
        hold(4'b0100, pat(2, 0), 100);
        hold(4'b0000, 8'hFF, 4);
        hold(4'b1000, pat(1, 0), 100);
        chk_out("blanking", 16'h1234, 4'b0001, 1'b0);
        chk("blanking_seen", 32'(BLANK_SEEN), 32'h1);
        chk("drain_pre_reset", 32'(exp_q.size()), 32'h0);

        // Reset in the middle of a stability count
        hold(4'b0001, 8'hC0, 30);
        RST = 1'b1;
        model_reset();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("midrst_value", 32'(VALUE), 32'h0);
        chk("midrst_dots",  32'(DOTS),  32'h0);
        chk("midrst_valid", 32'(VALID), 32'h0);
        chk("midrst_blank", 32'(BLANK_SEEN), 32'h0);
        @(posedge CLK); #1;
        RST = 1'b0;
        hold(4'b0001, 8'hC0, STABLE + 2 + 4);
        chk_out("post_rst", 16'h0000, 4'b0000, 1'b0);

`ifdef SEG7_CAPTURE_BCD_EN
        frame(9, 8, 7, 6, 4'b0000, 100);
        chk_out("bcd", 16'h6789, 4'b0000, 1'b0);
        chk("bcd_bin", 32'(BIN), 32'd6789);
        frame(1, 10, 2, 3, 4'b0000, 100);
        chk_out("bcd_hex", 16'h32A1, 4'b0000, 1'b1);
`endif

        // Randomized scanning
        for (int slot = 0; slot < 70; slot++) begin
            rd = 4'b0001 << $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) rs = 8'($urandom);
            else rs = pat($urandom_range(0, 15), 1'($urandom));
            rl = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 60) : $urandom_range(66, 120);
            hold(rd, rs, rl);
            if ($urandom_range(0, 4) == 0) hold(multi[$urandom_range(0, 4)], rs, $urandom_range(1, 4));
        end
        hold(4'b0000, 8'hFF, 20);
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        chk("final_drain", 32'(exp_q.size()), 32'h0);
        chk("final_blank", 32'(BLANK_SEEN), 32'(m_blank));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
